// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register-file reads for decoded rs/rt, captures
// the returned data one cycle later, and forwards in-flight writebacks so the
// operands handed to execute always reflect the newest architectural value.
// The register-file write port is a plain passthrough of the writeback bus.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [ADDR_W-1:0] rf_rd_0,
  output logic [ADDR_W-1:0] rf_rd_1,
  input  logic [DATA_W-1:0] rf_data_0,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op0,
  output logic [DATA_W-1:0] out_op1,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] rs_q, rt_q;
  logic [TAG_W-1:0]  tag_q, out_tag_q;
  logic              byp0_q, byp1_q;
  logic [DATA_W-1:0] byp_data0_q, byp_data1_q;
  logic [DATA_W-1:0] op0_q, op1_q, op0_d, op1_d;

  logic accept;
  logic wb_live;
  logic hit0_in, hit1_in;   // writeback targets the register being accepted
  logic hit0_q, hit1_q;     // writeback targets the latched register

  // Read addresses and write port are direct passthroughs
  assign rf_rd_0    = in_rs;
  assign rf_rd_1    = in_rt;
  assign rf_wr_en   = wb_en;
  assign rf_wr      = wb_reg;
  assign rf_wr_data = wb_data;

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // R0 is hardwired zero, so a write to it must never be forwarded
  assign wb_live = wb_en && (wb_reg != '0);
  assign hit0_in = wb_live && (wb_reg == in_rs);
  assign hit1_in = wb_live && (wb_reg == in_rt);
  assign hit0_q  = wb_live && (wb_reg == rs_q);
  assign hit1_q  = wb_live && (wb_reg == rt_q);

  assign out_valid = (state_q == HOLD);
  assign out_op0   = op0_q;
  assign out_op1   = op1_q;
  assign out_tag   = out_tag_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one request in flight, drain and accept may share a cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = FETCH;
      FETCH: state_d = HOLD;
      HOLD: begin
        if (out_ready) state_d = in_valid ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand selection: in FETCH the newest write wins over a write captured
  // at accept, which in turn wins over the (pre-write) rf data; in HOLD a
  // matching write updates the held operand in place
  always_comb begin
    op0_d = op0_q;
    op1_d = op1_q;
    unique case (state_q)
      FETCH: begin
        if (rs_q == '0)  op0_d = '0;
        else if (hit0_q) op0_d = wb_data;
        else if (byp0_q) op0_d = byp_data0_q;
        else             op0_d = rf_data_0;
        if (rt_q == '0)  op1_d = '0;
        else if (hit1_q) op1_d = wb_data;
        else if (byp1_q) op1_d = byp_data1_q;
        else             op1_d = rf_data_1;
      end
      HOLD: begin
        if (hit0_q) op0_d = wb_data;
        if (hit1_q) op1_d = wb_data;
      end
      default: ;
    endcase
  end

  // Request latch and accept-cycle bypass capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_q        <= '0;
      rt_q        <= '0;
      tag_q       <= '0;
      byp0_q      <= 1'b0;
      byp1_q      <= 1'b0;
      byp_data0_q <= '0;
      byp_data1_q <= '0;
    end else if (accept) begin
      rs_q   <= in_rs;
      rt_q   <= in_rt;
      tag_q  <= in_tag;
      byp0_q <= hit0_in;
      byp1_q <= hit1_in;
      if (hit0_in) byp_data0_q <= wb_data;
      if (hit1_in) byp_data1_q <= wb_data;
    end
  end

  // Output operand and tag registers; the tag is copied out of the request
  // latch in FETCH so a new accept during HOLD cannot disturb the held tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op0_q     <= '0;
      op1_q     <= '0;
      out_tag_q <= '0;
    end else begin
      op0_q <= op0_d;
      op1_q <= op1_d;
      if (state_q == FETCH) out_tag_q <= tag_q;
    end
  end

endmodule
